riscv_muldiv_sequencer: RTL and testbench

Iterative multiply/divide sequencer for the RV32M extension of the single-cycle RISC-V processor. It sits beside the controller and datapath.

- When the decoded instruction is an M-extension op, it stalls instruction commit by pulling `ex_no_stay` low.
- While stalled, it runs a shift-add multiplier or restoring divider for a fixed number of cycles.
- It then presents the result for write-back in the single cycle in which it releases the stall.

---
 rtl/riscv_muldiv_sequencer_if.sv | 12 +
 rtl/riscv_muldiv_sequencer.sv | 85 ++++++++
 tb/tb_riscv_muldiv_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_sequencer_if.sv
// riscv_muldiv_sequencer_if: controller <-> RV32M sequencer handshake and result bus
interface riscv_muldiv_sequencer_if #(parameter int REG_WIDTH = 32);
    logic                 md_valid;
    logic [2:0]           md_funct3;
    logic [REG_WIDTH-1:0] md_op_a;
    logic [REG_WIDTH-1:0] md_op_b;
    logic                 ex_no_stay;
    logic [REG_WIDTH-1:0] md_result;
    logic                 md_done;
    modport master (output md_valid, md_funct3, md_op_a, md_op_b, input ex_no_stay, md_result, md_done);
    modport slave  (input md_valid, md_funct3, md_op_a, md_op_b, output ex_no_stay, md_result, md_done);
endinterface

// File: rtl/riscv_muldiv_sequencer.sv
// riscv_muldiv_sequencer: iterative RV32M shift-add multiplier / restoring divider; divider built only with MULDIV_DIV_EN
module riscv_muldiv_sequencer #(
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = $clog2(REG_WIDTH) + 1
) (
    input logic clk,
    input logic rstn,
    riscv_muldiv_sequencer_if.slave bus
);
    localparam int W = REG_WIDTH;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0] acc, acc_nxt, mul_step, div_step, prod_s;
    logic [W-1:0] opnd, a_mag, b_mag, q, r, res, result;
    logic [W:0] sum, sh, diff;
    logic [1:0] sel;
    logic dv, qneg, rneg, done, go, div_sel, sgn_a, sgn_b, a_neg, b_neg;
`ifdef MULDIV_DIV_EN
    assign div_sel = bus.md_funct3[2];
    assign go = bus.md_valid;
`else
    assign div_sel = 1'b0;
    assign go = bus.md_valid && !bus.md_funct3[2];
`endif
    assign sgn_a = !(bus.md_funct3[0] && (bus.md_funct3[1] || bus.md_funct3[2]));
    assign sgn_b = sgn_a && bus.md_funct3 != 3'b010;
    assign a_neg = sgn_a && bus.md_op_a[W-1];
    assign b_neg = sgn_b && bus.md_op_b[W-1];
    assign a_mag = a_neg ? -bus.md_op_a : bus.md_op_a;
    assign b_mag = b_neg ? -bus.md_op_b : bus.md_op_b;
    // acc holds {partial product | remainder, multiplier | dividend->quotient}
    assign sum = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? opnd : {W{1'b0}}};
    assign mul_step = {sum, acc[W-1:1]};
    assign sh = {acc[2*W-1:W], acc[W-1]};
    assign diff = sh - {1'b0, opnd};
    assign div_step = diff[W] ? {sh[W-1:0], acc[W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
    assign acc_nxt = dv ? div_step : mul_step;
    assign prod_s = qneg ? -acc_nxt : acc_nxt;
    assign q = acc_nxt[W-1:0];
    assign r = acc_nxt[2*W-1:W];
    // a zero divisor leaves the remainder as the dividend naturally; only the quotient needs forcing
    assign res = dv ? (sel[1] ? (rneg ? -r : r) : (opnd == '0 ? {W{1'b1}} : (qneg ? -q : q)))
                    : (sel == 2'b00 ? prod_s[W-1:0] : prod_s[2*W-1:W]);
    assign bus.ex_no_stay = !(rstn && go && state != DONE);
    assign bus.md_result = result;
    assign bus.md_done = done;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            result <= '0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    opnd <= div_sel ? b_mag : a_mag;
                    acc <= {{W{1'b0}}, div_sel ? a_mag : b_mag};
                    dv <= div_sel;
                    sel <= bus.md_funct3[1:0];
                    qneg <= a_neg ^ b_neg;
                    rneg <= a_neg;
                    cnt <= '0;
                    state <= BUSY;
                end
                BUSY: if (!bus.md_valid) begin
                    state <= IDLE;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(W - 1)) begin
                        state <= DONE;
                        result <= res;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    result <= '0;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_sequencer.sv
// tb_riscv_muldiv_sequencer: scoreboard bench for the RV32M sequencer (follows MULDIV_DIV_EN)
module tb_riscv_muldiv_sequencer;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];
    riscv_muldiv_sequencer_if #(.REG_WIDTH(32)) bus ();
    riscv_muldiv_sequencer #(.REG_WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        logic signed [31:0] sa, sb;
        xa = (f == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
        xb = (f == 3'd0 || f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p = xa * xb;
        sa = a;
        sb = b;
        if (f == 3'd0) return p[31:0];
        if (!f[2]) return p[63:32];
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
        case (f)
            3'd4: return sa / sb;
            3'd5: return a / b;
            3'd6: return sa % sb;
            default: return a % b;
        endcase
    endfunction

    always @(negedge clk) if (bus.md_done) begin
        done_cnt++;
        if (exp_q.size() > 0) check("result", bus.md_result, exp_q.pop_front());
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.md_valid = 1'b1;
        bus.md_funct3 = f;
        bus.md_op_a = a;
        bus.md_op_b = b;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        bit seen;
        stalls = 0;
        seen = 1'b0;
        @(posedge clk) #1;
        drive(f, a, b);
        if (f[2] && !DIV_EN) begin
            @(negedge clk);
            check("div_off_nostay", 32'(bus.ex_no_stay), 32'd1);
            repeat (3) begin
                @(negedge clk);
                check("div_off_done", 32'(bus.md_done), 32'd0);
                check("div_off_result", bus.md_result, 32'd0);
            end
        end else begin
            exp_q.push_back(model(f, a, b));
            for (int n = 0; n < 100 && !seen; n++) begin
                @(negedge clk);
                if (bus.md_done) begin
                    seen = 1'b1;
                    check("commit_nostay", 32'(bus.ex_no_stay), 32'd1);
                end else if (!bus.ex_no_stay) stalls++;
            end
            check("done_seen", 32'(seen), 32'd1);
            check("stall_cycles", 32'(stalls), 32'd33);
        end
        @(posedge clk) #1;
        bus.md_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(bus.md_done), 32'd0);
        check("result_idle", bus.md_result, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, d0;
        drive(3'd0, 32'd7, 32'd3);
        repeat (2) begin
            @(negedge clk);
            check("rst_nostay", 32'(bus.ex_no_stay), 32'd1);
            check("rst_done", 32'(bus.md_done), 32'd0);
            check("rst_result", bus.md_result, 32'd0);
        end
        @(posedge clk) #1;
        rstn = 1'b1;
        bus.md_valid = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd100, 32'd7);
        for (int i = 0; i < 16; i++) run_op(3'(i % 8), $urandom, $urandom);

        // back-to-back MULs commit 34 cycles apart
        first = -1;
        second = -1;
        exp_q.push_back(model(3'd0, 32'd12345, 32'd678));
        exp_q.push_back(model(3'd0, 32'hDEAD_BEEF, 32'hFFFF_0001));
        @(posedge clk) #1;
        drive(3'd0, 32'd12345, 32'd678);
        for (int n = 0; n < 120 && second < 0; n++) begin
            @(negedge clk);
            if (bus.md_done) begin
                if (first < 0) begin
                    first = n;
                    @(posedge clk) #1;
                    drive(3'd0, 32'hDEAD_BEEF, 32'hFFFF_0001);
                end else second = n;
            end
        end
        check("b2b_gap", 32'(second - first), 32'd34);
        @(posedge clk) #1;
        bus.md_valid = 1'b0;

        // reset in BUSY cycle 10 discards the operation
        d0 = done_cnt;
        @(posedge clk) #1;
        drive(3'd0, 32'd9, 32'd9);
        @(negedge clk);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1 check("midrst_nostay", 32'(bus.ex_no_stay), 32'd1);
        @(negedge clk);
        check("midrst_result", bus.md_result, 32'd0);
        check("midrst_done", 32'(bus.md_done), 32'd0);
        check("midrst_nostay_held", 32'(bus.ex_no_stay), 32'd1);
        @(posedge clk) #1;
        rstn = 1'b1;
        bus.md_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(3'd0, 32'd9, 32'd9);

        // dropping md_valid mid-operation aborts with no result
        d0 = done_cnt;
        @(posedge clk) #1;
        drive(3'd3, 32'd5, 32'd6);
        repeat (6) @(negedge clk);
        bus.md_valid = 1'b0;
        #1 check("abort_nostay", 32'(bus.ex_no_stay), 32'd1);
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
